// File: rtl/dual_boxcar_dec.sv
// Two-channel boxcar post-decimator: splits the ab-interleaved stream, accumulates N pairs per frame,
// then rounds, shifts and saturates both sums and emits them together; also polices the ab phasing.
module dual_boxcar_dec #(
  parameter int dw = 17,
  parameter int cw = 8,
  parameter int ow = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ab,
  input  logic signed [dw-1:0] d,
  input  logic [cw-1:0]        dec_n,
  input  logic [4:0]           shift,
  output logic signed [ow-1:0] ya,
  output logic signed [ow-1:0] yb,
  output logic                 y_stb,
  output logic                 phase_err
);

  localparam int AW = dw + cw;
  localparam int RW = AW + 1;
  localparam logic [4:0] SMAX = 5'(AW - 1);
  localparam logic signed [RW-1:0] OMAX = RW'((2 ** (ow - 1)) - 1);
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  logic                 abD_q, abD_d, abValid_q, abValid_d;
  logic [1:0]           runLen_q, runLen_d;
  logic                 runKnown_q, runKnown_d;
  logic                 phaseEv, perr_q, perr_d;

  logic                 inFrame_q, inFrame_d;
  logic [cw-1:0]        cnt_q, cnt_d, decN_q, decN_d;
  logic [4:0]           shift_q, shift_d;
  logic signed [AW-1:0] accA_q, accA_d, accB_q, accB_d;
  logic                 aCap, bCap, dump;
  logic signed [AW-1:0] dExt;

  logic signed [AW-1:0] sumA_q, sumA_d, sumB_q, sumB_d;
  logic [4:0]           sh1_q, sh1_d;
  logic signed [RW-1:0] rA_q, rA_d, rB_q, rB_d;
  logic signed [ow-1:0] ya_q, ya_d, yb_q, yb_d;
  logic                 stb1_q, stb2_q, stb3_q;

  function automatic logic signed [RW-1:0] roundShift(input logic signed [AW-1:0] sum,
                                                       input logic [4:0] s);
    logic signed [RW-1:0] wide;
    logic signed [RW-1:0] bias;
    wide = {sum[AW-1], sum};
    bias = '0;
    if (s != 5'd0) bias = {{(RW-1){1'b0}}, 1'b1} << (s - 5'd1);
    return (wide + bias) >>> s;
  endfunction

  function automatic logic signed [ow-1:0] saturate(input logic signed [RW-1:0] r);
    if (r > OMAX)      return OMAX[ow-1:0];
    else if (r < OMIN) return OMIN[ow-1:0];
    else               return r[ow-1:0];
  endfunction

  assign dExt = {{cw{d[dw-1]}}, d};
  assign aCap = abValid_q & ~ab & ~abD_q;
  assign bCap = abValid_q & ab & abD_q & inFrame_q;

  // The first run after reset may be truncated, so a short run is only an error once a transition was seen.
  always_comb begin
    abD_d      = ab;
    abValid_d  = 1'b1;
    runLen_d   = 2'd1;
    runKnown_d = runKnown_q;
    phaseEv    = 1'b0;
    if (abValid_q) begin
      if (ab == abD_q) begin
        runLen_d = (runLen_q == 2'd3) ? 2'd3 : runLen_q + 2'd1;
        phaseEv  = (runLen_q >= 2'd2);
      end else begin
        runKnown_d = 1'b1;
        phaseEv    = runKnown_q && (runLen_q == 2'd1);
      end
    end
    perr_d = perr_q | phaseEv;
  end

  always_comb begin
    inFrame_d = inFrame_q;
    cnt_d     = cnt_q;
    decN_d    = decN_q;
    shift_d   = shift_q;
    accA_d    = accA_q;
    accB_d    = accB_q;
    dump      = 1'b0;
    if (phaseEv) begin
      inFrame_d = 1'b0;
      cnt_d     = '0;
      accA_d    = '0;
      accB_d    = '0;
    end else if (aCap) begin
      if (!inFrame_q) begin
        inFrame_d = 1'b1;
        cnt_d     = '0;
        decN_d    = dec_n;
        shift_d   = shift;
        accA_d    = dExt;
      end else begin
        accA_d = accA_q + dExt;
      end
    end else if (bCap) begin
      accB_d = (cnt_q == '0) ? dExt : accB_q + dExt;
      if (cnt_q == decN_q) begin
        dump      = 1'b1;
        inFrame_d = 1'b0;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // The shift travels with its sums so a new frame's setting cannot leak into the previous result.
  always_comb begin
    sumA_d = sumA_q;
    sumB_d = sumB_q;
    sh1_d  = sh1_q;
    rA_d   = rA_q;
    rB_d   = rB_q;
    ya_d   = ya_q;
    yb_d   = yb_q;
    if (dump) begin
      sumA_d = accA_q;
      sumB_d = accB_d;
      sh1_d  = (shift_q > SMAX) ? SMAX : shift_q;
    end
    if (stb1_q) begin
      rA_d = roundShift(sumA_q, sh1_q);
      rB_d = roundShift(sumB_q, sh1_q);
    end
    if (stb2_q) begin
      ya_d = saturate(rA_q);
      yb_d = saturate(rB_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abD_q      <= 1'b0;
      abValid_q  <= 1'b0;
      runLen_q   <= 2'd0;
      runKnown_q <= 1'b0;
      perr_q     <= 1'b0;
      inFrame_q  <= 1'b0;
      cnt_q      <= '0;
      decN_q     <= '0;
      shift_q    <= '0;
      accA_q     <= '0;
      accB_q     <= '0;
      sumA_q     <= '0;
      sumB_q     <= '0;
      sh1_q      <= '0;
      rA_q       <= '0;
      rB_q       <= '0;
      ya_q       <= '0;
      yb_q       <= '0;
      stb1_q     <= 1'b0;
      stb2_q     <= 1'b0;
      stb3_q     <= 1'b0;
    end else begin
      abD_q      <= abD_d;
      abValid_q  <= abValid_d;
      runLen_q   <= runLen_d;
      runKnown_q <= runKnown_d;
      perr_q     <= perr_d;
      inFrame_q  <= inFrame_d;
      cnt_q      <= cnt_d;
      decN_q     <= decN_d;
      shift_q    <= shift_d;
      accA_q     <= accA_d;
      accB_q     <= accB_d;
      sumA_q     <= sumA_d;
      sumB_q     <= sumB_d;
      sh1_q      <= sh1_d;
      rA_q       <= rA_d;
      rB_q       <= rB_d;
      ya_q       <= ya_d;
      yb_q       <= yb_d;
      stb1_q     <= dump;
      stb2_q     <= stb1_q;
      stb3_q     <= stb2_q;
    end
  end

  assign ya        = ya_q;
  assign yb        = yb_q;
  assign y_stb     = stb3_q;
  assign phase_err = perr_q;

endmodule

// File: tb/tb_dual_boxcar_dec.sv
// Directed bench for dual_boxcar_dec: each task drives a scenario with hand-computed results
// and compares the strobed outputs recorded by a negedge monitor.
module tb_dual_boxcar_dec;

  logic               clk = 1'b0;
  logic               rst;
  logic               ab;
  logic signed [16:0] d;
  logic [7:0]         dec_n;
  logic [4:0]         shift;
  logic signed [17:0] ya, yb;
  logic               y_stb, phase_err;

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;
  int lastBcap   = 0;

  int                 stbCyc[$];
  logic signed [17:0] stbYa[$];
  logic signed [17:0] stbYb[$];

  dual_boxcar_dec dut (
    .clk      (clk),
    .rst      (rst),
    .ab       (ab),
    .d        (d),
    .dec_n    (dec_n),
    .shift    (shift),
    .ya       (ya),
    .yb       (yb),
    .y_stb    (y_stb),
    .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log: cycle number and the paired values visible while y_stb is high.
  always @(negedge clk) begin
    if (y_stb === 1'b1) begin
      stbCyc.push_back(cyc);
      stbYa.push_back(ya);
      stbYb.push_back(yb);
    end
  end

  function automatic logic signed [17:0] yaAt(input int i);
    return (i < stbYa.size()) ? stbYa[i] : 18'sbx;
  endfunction

  function automatic logic signed [17:0] ybAt(input int i);
    return (i < stbYb.size()) ? stbYb[i] : 18'sbx;
  endfunction

  function automatic int cycAt(input int i);
    return (i < stbCyc.size()) ? stbCyc[i] : -1;
  endfunction

  // One clean ab period: two cycles of channel a, then two of channel b; captures land on the 2nd of each.
  task automatic drivePair(input int a, input int b);
    ab = 1'b0; d = 17'(a); @(negedge clk);
    ab = 1'b0; d = 17'(a); @(negedge clk);
    ab = 1'b1; d = 17'(b); @(negedge clk);
    ab = 1'b1; d = 17'(b); lastBcap = cyc; @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1'b1; ab = 1'b0; d = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ab = 1'b0; d = 17'sd5; dec_n = '0; shift = '0;
    repeat (3) begin ab = ~ab; @(negedge clk); end
    checkCount++; if (ya !== 18'sd0) $display("[TB] FAIL reset_ya: got %0d expected 0", ya); else passCount++;
    checkCount++; if (yb !== 18'sd0) $display("[TB] FAIL reset_yb: got %0d expected 0", yb); else passCount++;
    checkCount++; if (y_stb !== 1'b0) $display("[TB] FAIL reset_stb: got %b expected 0", y_stb); else passCount++;
    checkCount++; if (phase_err !== 1'b0) $display("[TB] FAIL reset_perr: got %b expected 0", phase_err); else passCount++;
  endtask

  task automatic test_average();
    int base;
    int bcap4;
    applyReset();
    dec_n = 8'd3; shift = 5'd2;
    base = stbYa.size();
    bcap4 = 0;
    for (int i = 0; i < 12; i++) begin
      drivePair(1000, -1000);
      if (i == 3) bcap4 = lastBcap;
    end
    drivePair(1000, -1000);
    checkCount++; if (stbYa.size() - base != 3) $display("[TB] FAIL avg_count: got %0d expected 3", stbYa.size() - base); else passCount++;
    checkCount++; if (cycAt(base) != bcap4 + 3) $display("[TB] FAIL avg_latency: got cycle %0d expected %0d", cycAt(base), bcap4 + 3); else passCount++;
    checkCount++; if (cycAt(base + 1) - cycAt(base) != 16) $display("[TB] FAIL avg_period1: got %0d expected 16", cycAt(base + 1) - cycAt(base)); else passCount++;
    checkCount++; if (cycAt(base + 2) - cycAt(base + 1) != 16) $display("[TB] FAIL avg_period2: got %0d expected 16", cycAt(base + 2) - cycAt(base + 1)); else passCount++;
    checkCount++; if (yaAt(base + 2) !== 18'sd1000) $display("[TB] FAIL avg_ya: got %0d expected 1000", yaAt(base + 2)); else passCount++;
    checkCount++; if (ybAt(base + 2) !== -18'sd1000) $display("[TB] FAIL avg_yb: got %0d expected -1000", ybAt(base + 2)); else passCount++;
  endtask

  task automatic test_rounding();
    int base;
    applyReset();
    dec_n = 8'd1; shift = 5'd1;
    base = stbYa.size();
    drivePair(1, -1);
    drivePair(2, -2);
    drivePair(0, 0);
    checkCount++; if (stbYa.size() - base != 1) $display("[TB] FAIL round_count: got %0d expected 1", stbYa.size() - base); else passCount++;
    checkCount++; if (yaAt(base) !== 18'sd2) $display("[TB] FAIL round_ya: got %0d expected 2", yaAt(base)); else passCount++;
    checkCount++; if (ybAt(base) !== -18'sd1) $display("[TB] FAIL round_yb: got %0d expected -1", ybAt(base)); else passCount++;
  endtask

  task automatic test_saturation();
    int base;
    applyReset();
    dec_n = 8'd3; shift = 5'd0;
    base = stbYa.size();
    repeat (4) drivePair(65535, -65536);
    drivePair(0, 0);
    checkCount++; if (stbYa.size() - base != 1) $display("[TB] FAIL sat_count: got %0d expected 1", stbYa.size() - base); else passCount++;
    checkCount++; if (yaAt(base) !== 18'sd131071) $display("[TB] FAIL sat_ya: got %0d expected 131071", yaAt(base)); else passCount++;
    checkCount++; if (ybAt(base) !== -18'sd131072) $display("[TB] FAIL sat_yb: got %0d expected -131072", ybAt(base)); else passCount++;
  endtask

  task automatic test_wrap();
    int base;
    applyReset();
    dec_n = 8'd255; shift = 5'd8;
    base = stbYa.size();
    repeat (256) drivePair(65535, -65536);
    drivePair(0, 0);
    checkCount++; if (stbYa.size() - base != 1) $display("[TB] FAIL wrap_count: got %0d expected 1", stbYa.size() - base); else passCount++;
    checkCount++; if (yaAt(base) !== 18'sd65535) $display("[TB] FAIL wrap_ya: got %0d expected 65535", yaAt(base)); else passCount++;
    checkCount++; if (ybAt(base) !== -18'sd65536) $display("[TB] FAIL wrap_yb: got %0d expected -65536", ybAt(base)); else passCount++;
  endtask

  task automatic test_mid_change();
    int base;
    applyReset();
    dec_n = 8'd3; shift = 5'd0;
    base = stbYa.size();
    drivePair(10, -20);
    drivePair(10, -20);
    dec_n = 8'd0;
    drivePair(10, -20);
    drivePair(10, -20);
    repeat (4) drivePair(7, -3);
    checkCount++; if (stbYa.size() - base != 4) $display("[TB] FAIL mid_count: got %0d expected 4", stbYa.size() - base); else passCount++;
    checkCount++; if (yaAt(base) !== 18'sd40) $display("[TB] FAIL mid_first_ya: got %0d expected 40", yaAt(base)); else passCount++;
    checkCount++; if (ybAt(base) !== -18'sd80) $display("[TB] FAIL mid_first_yb: got %0d expected -80", ybAt(base)); else passCount++;
    checkCount++; if (yaAt(base + 3) !== 18'sd7) $display("[TB] FAIL mid_last_ya: got %0d expected 7", yaAt(base + 3)); else passCount++;
    checkCount++; if (ybAt(base + 3) !== -18'sd3) $display("[TB] FAIL mid_last_yb: got %0d expected -3", ybAt(base + 3)); else passCount++;
    checkCount++; if (cycAt(base + 3) - cycAt(base + 2) != 4) $display("[TB] FAIL mid_period: got %0d expected 4", cycAt(base + 3) - cycAt(base + 2)); else passCount++;
  endtask

  task automatic test_phase_err();
    int base;
    applyReset();
    dec_n = 8'd3; shift = 5'd2;
    base = stbYa.size();
    drivePair(100, -100);
    drivePair(100, -100);
    ab = 1'b0; d = 17'sd100; @(negedge clk);
    ab = 1'b0; @(negedge clk);
    checkCount++; if (phase_err !== 1'b0) $display("[TB] FAIL perr_before: got %b expected 0", phase_err); else passCount++;
    ab = 1'b0; @(negedge clk);
    checkCount++; if (phase_err !== 1'b1) $display("[TB] FAIL perr_set: got %b expected 1", phase_err); else passCount++;
    ab = 1'b1; d = -17'sd100; @(negedge clk);
    ab = 1'b1; @(negedge clk);
    repeat (4) drivePair(300, -300);
    drivePair(0, 0);
    checkCount++; if (stbYa.size() - base != 1) $display("[TB] FAIL perr_count: got %0d expected 1", stbYa.size() - base); else passCount++;
    checkCount++; if (yaAt(base) !== 18'sd300) $display("[TB] FAIL perr_ya: got %0d expected 300", yaAt(base)); else passCount++;
    checkCount++; if (ybAt(base) !== -18'sd300) $display("[TB] FAIL perr_yb: got %0d expected -300", ybAt(base)); else passCount++;
    checkCount++; if (phase_err !== 1'b1) $display("[TB] FAIL perr_sticky: got %b expected 1", phase_err); else passCount++;
  endtask

  task automatic test_dump_abort();
    int base;
    applyReset();
    dec_n = 8'd1; shift = 5'd0;
    base = stbYa.size();
    ab = 1'b0; d = 17'sd9; @(negedge clk);
    ab = 1'b0; @(negedge clk);
    ab = 1'b1; @(negedge clk);
    ab = 1'b1; @(negedge clk);
    ab = 1'b1; @(negedge clk);
    checkCount++; if (phase_err !== 1'b1) $display("[TB] FAIL abort_perr: got %b expected 1", phase_err); else passCount++;
    drivePair(5, 6);
    drivePair(5, 6);
    drivePair(0, 0);
    checkCount++; if (stbYa.size() - base != 1) $display("[TB] FAIL abort_count: got %0d expected 1", stbYa.size() - base); else passCount++;
    checkCount++; if (yaAt(base) !== 18'sd10) $display("[TB] FAIL abort_ya: got %0d expected 10", yaAt(base)); else passCount++;
    checkCount++; if (ybAt(base) !== 18'sd12) $display("[TB] FAIL abort_yb: got %0d expected 12", ybAt(base)); else passCount++;
  endtask

  task automatic test_reset_mid();
    int base;
    int bcap4;
    applyReset();
    dec_n = 8'd3; shift = 5'd0;
    repeat (4) drivePair(50, 60);
    drivePair(1000, 1000);
    drivePair(1000, 1000);
    checkCount++; if (ya !== 18'sd200) $display("[TB] FAIL rmid_pre_ya: got %0d expected 200", ya); else passCount++;
    rst = 1'b1; ab = 1'b0; d = '0; @(negedge clk);
    checkCount++; if (ya !== 18'sd0) $display("[TB] FAIL rmid_ya: got %0d expected 0", ya); else passCount++;
    checkCount++; if (yb !== 18'sd0) $display("[TB] FAIL rmid_yb: got %0d expected 0", yb); else passCount++;
    checkCount++; if (y_stb !== 1'b0) $display("[TB] FAIL rmid_stb: got %b expected 0", y_stb); else passCount++;
    rst = 1'b0;
    base = stbYa.size();
    bcap4 = 0;
    for (int i = 0; i < 4; i++) begin
      drivePair(3, 4);
      if (i == 3) bcap4 = lastBcap;
    end
    drivePair(0, 0);
    checkCount++; if (stbYa.size() - base != 1) $display("[TB] FAIL rmid_count: got %0d expected 1", stbYa.size() - base); else passCount++;
    checkCount++; if (cycAt(base) != bcap4 + 3) $display("[TB] FAIL rmid_latency: got cycle %0d expected %0d", cycAt(base), bcap4 + 3); else passCount++;
    checkCount++; if (yaAt(base) !== 18'sd12) $display("[TB] FAIL rmid_post_ya: got %0d expected 12", yaAt(base)); else passCount++;
    checkCount++; if (ybAt(base) !== 18'sd16) $display("[TB] FAIL rmid_post_yb: got %0d expected 16", ybAt(base)); else passCount++;
  endtask

  initial begin
    rst = 1'b1; ab = 1'b0; d = '0; dec_n = '0; shift = '0;
    @(negedge clk);
    test_reset();
    test_average();
    test_rounding();
    test_saturation();
    test_wrap();
    test_mid_change();
    test_phase_err();
    test_dump_abort();
    test_reset_mid();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
